pc_stack_unit: RTL and testbench



---
 rtl/pc_stack_unit_pkg.sv | 9 +
 rtl/pic_hw_stack.sv | 48 ++++
 rtl/pc_stack_unit.sv | 53 +++++
 tb/tb_pc_stack_unit.sv | 77 +++++++
 4 files changed

// File: rtl/pc_stack_unit_pkg.sv
// pc_stack_unit_pkg: shared stack command codes, PCL address and reset vector
package pc_stack_unit_pkg;
  localparam logic [1:0] STK_NOP = 2'b00;
  localparam logic [1:0] STK_PUSH = 2'b01;
  localparam logic [1:0] STK_POP = 2'b10;
  localparam logic [7:0] PCL_ADDR = 8'h02;
  localparam int PC_WIDTH_DEF = 11;
  localparam logic [10:0] RESET_VEC_DEF = 11'h7FF;
endpackage

// File: rtl/pic_hw_stack.sv
// pic_hw_stack: shift-register return stack with depth counter and sticky over/underflow
module pic_hw_stack #(
  parameter int W = 11,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] tos,
  output logic [1:0]   depth,
  output logic         ovf,
  output logic         unf
);
  logic [W-1:0] e [DEPTH];
  assign tos = e[0];
  for (genvar i = 0; i < DEPTH; i++) begin : g_e
    logic [W-1:0] below, above;
    if (i == DEPTH - 1) begin : g_last
      assign below = e[i];
    end else begin : g_mid
      assign below = e[i+1];
    end
    if (i == 0) begin : g_first
      assign above = din;
    end else begin : g_rest
      assign above = e[i-1];
    end
    // the last entry keeps its value on pop, so it duplicates upward
    always_ff @(posedge clk)
      if (!rst_n) e[i] <= '0;
      else if (pop) e[i] <= below;
      else if (push) e[i] <= above;
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      depth <= '0;
      ovf <= 1'b0;
      unf <= 1'b0;
    end else if (pop) begin
      depth <= (depth == 2'd0) ? 2'd0 : depth - 2'd1;
      unf <= unf | (depth == 2'd0);
    end else if (push) begin
      depth <= (depth == 2'(DEPTH)) ? depth : depth + 2'd1;
      ovf <= ovf | (depth == 2'(DEPTH));
    end
endmodule

// File: rtl/pc_stack_unit.sv
// pc_stack_unit: PIC16C5x program counter with priority load mux and 2-level return stack
import pc_stack_unit_pkg::*;
module pc_stack_unit #(
  parameter int PC_WIDTH = PC_WIDTH_DEF,
  parameter int STACK_DEPTH = 2,
  parameter logic [PC_WIDTH-1:0] RESET_VEC = {PC_WIDTH{1'b1}}
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                pc_inc,
  input  logic [1:0]          stk_cmd,
  input  logic                goto_ld,
  input  logic                pcl_we,
  input  logic [7:0]          pcl_din,
  input  logic [11:0]         inst_in,
  input  logic [1:0]          status_pa,
  output logic [PC_WIDTH-1:0] pc_out,
  output logic [1:0]          stk_depth,
  output logic                stk_ovf,
  output logic                stk_unf
);
  logic pop, push;
  logic [PC_WIDTH-1:0] tos, pc_nx;
  logic [10:0] call_t, goto_t, pcl_t;
  logic unused_inst;
  assign unused_inst = &{1'b0, inst_in[11:9]};
  assign pop = stk_cmd == STK_POP;
  assign push = stk_cmd == STK_PUSH;
  // CALL and PCL writes cannot reach bit 8, so it is forced low
  assign call_t = {status_pa, 1'b0, inst_in[7:0]};
  assign goto_t = {status_pa, inst_in[8:0]};
  assign pcl_t = {status_pa, 1'b0, pcl_din};
  always_comb
    pc_nx = pop ? tos :
            push ? PC_WIDTH'(call_t) :
            goto_ld ? PC_WIDTH'(goto_t) :
            pcl_we ? PC_WIDTH'(pcl_t) :
            pc_inc ? pc_out + PC_WIDTH'(1) : pc_out;
  always_ff @(posedge clk)
    if (!rst_n) pc_out <= RESET_VEC;
    else pc_out <= pc_nx;
  pic_hw_stack #(.W(PC_WIDTH), .DEPTH(STACK_DEPTH)) u_stack (
    .clk(clk),
    .rst_n(rst_n),
    .push(push),
    .pop(pop),
    .din(pc_out),
    .tos(tos),
    .depth(stk_depth),
    .ovf(stk_ovf),
    .unf(stk_unf)
  );
endmodule

// File: tb/tb_pc_stack_unit.sv
// tb_pc_stack_unit: table-driven directed check of PC, stack depth and sticky flags
module tb_pc_stack_unit;
  logic clk = 0, rst_n, pc_inc, goto_ld, pcl_we;
  logic [1:0] stk_cmd, status_pa, stk_depth;
  logic [7:0] pcl_din;
  logic [11:0] inst_in;
  logic [10:0] pc_out;
  logic stk_ovf, stk_unf;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  pc_stack_unit dut (
    .clk(clk), .rst_n(rst_n), .pc_inc(pc_inc), .stk_cmd(stk_cmd),
    .goto_ld(goto_ld), .pcl_we(pcl_we), .pcl_din(pcl_din), .inst_in(inst_in),
    .status_pa(status_pa), .pc_out(pc_out), .stk_depth(stk_depth),
    .stk_ovf(stk_ovf), .stk_unf(stk_unf)
  );
  typedef struct packed {
    logic rst_n, inc;
    logic [1:0] cmd;
    logic go, pw;
    logic [7:0] din;
    logic [11:0] inst;
    logic [1:0] pa;
    logic [10:0] pc;
    logic [1:0] d;
    logic o, u;
  } vec_t;
  vec_t tv [26];
  task automatic chk(input string n, input int i, input logic [10:0] a, input logic [10:0] r);
    checks++;
    if (a !== r) begin
      failures++;
      $display("FAIL %s step %0d: got %h expected %h", n, i, a, r);
    end
  endtask
  initial begin
    //        rst inc cmd   go pw din    inst     pa     pc      d  o  u
    tv[0]  = '{0, 0, 2'b00, 0, 0, 8'h00, 12'h000, 2'b00, 11'h7FF, 0, 0, 0};
    tv[1]  = '{1, 1, 2'b00, 0, 0, 8'h00, 12'h000, 2'b00, 11'h000, 0, 0, 0};
    tv[2]  = '{1, 1, 2'b00, 0, 0, 8'h00, 12'h000, 2'b00, 11'h001, 0, 0, 0};
    tv[3]  = '{1, 0, 2'b00, 1, 0, 8'h00, 12'h123, 2'b00, 11'h123, 0, 0, 0};
    tv[4]  = '{1, 0, 2'b01, 0, 0, 8'h00, 12'h9AB, 2'b01, 11'h2AB, 1, 0, 0};
    tv[5]  = '{1, 0, 2'b10, 0, 0, 8'h00, 12'h000, 2'b00, 11'h123, 0, 0, 0};
    tv[6]  = '{1, 0, 2'b00, 1, 0, 8'h00, 12'h010, 2'b00, 11'h010, 0, 0, 0};
    tv[7]  = '{1, 0, 2'b01, 0, 0, 8'h00, 12'h000, 2'b00, 11'h000, 1, 0, 0};
    tv[8]  = '{1, 0, 2'b00, 1, 0, 8'h00, 12'h020, 2'b00, 11'h020, 1, 0, 0};
    tv[9]  = '{1, 0, 2'b01, 0, 0, 8'h00, 12'h000, 2'b00, 11'h000, 2, 0, 0};
    tv[10] = '{1, 0, 2'b00, 1, 0, 8'h00, 12'h030, 2'b00, 11'h030, 2, 0, 0};
    tv[11] = '{1, 0, 2'b01, 0, 0, 8'h00, 12'h055, 2'b00, 11'h055, 2, 1, 0};
    tv[12] = '{1, 0, 2'b10, 0, 0, 8'h00, 12'h000, 2'b00, 11'h030, 1, 1, 0};
    tv[13] = '{1, 0, 2'b10, 0, 0, 8'h00, 12'h000, 2'b00, 11'h020, 0, 1, 0};
    tv[14] = '{1, 0, 2'b10, 0, 0, 8'h00, 12'h000, 2'b00, 11'h020, 0, 1, 1};
    tv[15] = '{1, 0, 2'b00, 1, 0, 8'h00, 12'hBFF, 2'b11, 11'h7FF, 0, 1, 1};
    tv[16] = '{1, 0, 2'b00, 0, 1, 8'h80, 12'h000, 2'b10, 11'h480, 0, 1, 1};
    tv[17] = '{1, 1, 2'b00, 1, 0, 8'h00, 12'h005, 2'b00, 11'h005, 0, 1, 1};
    tv[18] = '{1, 1, 2'b01, 1, 1, 8'h11, 12'h0AA, 2'b00, 11'h0AA, 1, 1, 1};
    tv[19] = '{1, 0, 2'b01, 0, 0, 8'h00, 12'h033, 2'b00, 11'h033, 2, 1, 1};
    tv[20] = '{1, 1, 2'b11, 0, 0, 8'h00, 12'h000, 2'b00, 11'h034, 2, 1, 1};
    tv[21] = '{1, 1, 2'b10, 1, 1, 8'h22, 12'h077, 2'b00, 11'h0AA, 1, 1, 1};
    tv[22] = '{1, 1, 2'b00, 0, 1, 8'h44, 12'h000, 2'b01, 11'h244, 1, 1, 1};
    tv[23] = '{0, 1, 2'b01, 1, 1, 8'h00, 12'h0AA, 2'b01, 11'h7FF, 0, 0, 0};
    tv[24] = '{1, 0, 2'b10, 0, 0, 8'h00, 12'h000, 2'b00, 11'h000, 0, 0, 1};
    tv[25] = '{1, 1, 2'b00, 0, 0, 8'h00, 12'h000, 2'b00, 11'h001, 0, 0, 1};
    for (int i = 0; i < 26; i++) begin
      {rst_n, pc_inc, stk_cmd, goto_ld, pcl_we, pcl_din, inst_in, status_pa} =
        {tv[i].rst_n, tv[i].inc, tv[i].cmd, tv[i].go, tv[i].pw, tv[i].din, tv[i].inst, tv[i].pa};
      @(posedge clk);
      #1;
      chk("pc_out", i, pc_out, tv[i].pc);
      chk("stk_depth", i, 11'(stk_depth), 11'(tv[i].d));
      chk("stk_ovf", i, 11'(stk_ovf), 11'(tv[i].o));
      chk("stk_unf", i, 11'(stk_unf), 11'(tv[i].u));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
